// File: rtl/ps2_key_tracker_if.sv
// Key-event stream between the PS/2 tracker and the downstream display path.
// ev_data layout: [10] repeat, [9] ext, [8] brk, [7:0] scan code.
interface ps2_key_tracker_if;
  logic [10:0] ev_data;
  logic        ev_valid;
  logic        ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: oversampled deframer, make/break/E0 decoder,
// held-key tracker with repeat detection, and a small event FIFO.
module ps2_key_tracker #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int DROP_REPEAT = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_key_tracker_if.master ev,
  output logic             key_down,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             frame_err,
  output logic             overflow
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  // ---------------- synchroniser + deframer ----------------
  logic [2:0]      clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [8:0]      shift_q, shift_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            byte_vld_q, byte_vld_d;
  logic [7:0]      byte_q, byte_d;
  logic            fall, sample, fr_err;

  assign fall   = (clk_sync_q[2:1] == 2'b10);
  assign sample = dat_sync_q[1];

  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[1:0], ps2_data};
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    to_cnt_d   = to_cnt_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    fr_err     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (!sample) bit_cnt_d = 4'd1;
        else         fr_err    = 1'b1;
      end else if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // shift_q holds 8 data bits plus parity; odd parity means XOR == 1
        if (sample && (^shift_q)) begin
          byte_vld_d = 1'b1;
          byte_d     = shift_q[7:0];
        end else begin
          fr_err = 1'b1;
        end
      end else begin
        shift_d   = {sample, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
        fr_err    = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // ---------------- decoder FSM ----------------
  state_t state_q, state_d;
  logic   emit_make, emit_brk, emit_ext, dec_err;

  always_ff @(posedge clk) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_vld_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_q == 8'hE0)      state_d = S_EXT;
          else if (byte_q == 8'hF0) state_d = S_BRK;
        end
        S_EXT: begin
          if (byte_q == 8'hF0)      state_d = S_EXT_BRK;
          else if (byte_q != 8'hE0) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    emit_make = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    dec_err   = 1'b0;
    if (byte_vld_q) begin
      unique case (state_q)
        S_IDLE: begin
          // 00/AA/FF are keyboard status bytes, not keys
          emit_make = !(byte_q inside {8'hE0, 8'hF0, 8'h00, 8'hAA, 8'hFF});
        end
        S_EXT: begin
          emit_make = !(byte_q inside {8'hE0, 8'hF0});
          emit_ext  = 1'b1;
        end
        default: begin
          emit_ext = (state_q == S_EXT_BRK);
          if (byte_q inside {8'hE0, 8'hF0}) dec_err  = 1'b1;
          else                              emit_brk = 1'b1;
        end
      endcase
    end
  end

  // ---------------- held-key tracking ----------------
  logic             key_down_q, key_down_d, key_ext_q, key_ext_d;
  logic [7:0]       key_code_q, key_code_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             push_q, push_d;
  logic [10:0]      word_q, word_d;
  logic             frame_err_q, frame_err_d;
  logic             match, is_repeat;

  assign match     = key_down_q && ({emit_ext, byte_q} == {key_ext_q, key_code_q});
  assign is_repeat = emit_make && match;

  always_comb begin
    key_down_d    = key_down_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    press_count_d = press_count_q;
    if (emit_make && !match) begin
      key_down_d    = 1'b1;
      key_code_d    = byte_q;
      key_ext_d     = emit_ext;
      press_count_d = press_count_q + CNT_W'(1);
    end
    if (emit_brk && match) key_down_d = 1'b0;
    push_d      = emit_brk || (emit_make && (!match || (DROP_REPEAT == 0)));
    word_d      = {is_repeat, emit_ext, emit_brk, byte_q};
    frame_err_d = fr_err || dec_err;
  end

  // ---------------- event FIFO ----------------
  logic [10:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          pop, full, wr_en;

  assign pop   = (count_q != '0) && ev.ev_ready;
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en = push_q && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!wr_en && pop) count_d = count_q - (AW+1)'(1);
    overflow_d = overflow_q || (push_q && !wr_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= word_q;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync_q    <= 3'b111;
      dat_sync_q    <= 3'b111;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      to_cnt_q      <= '0;
      byte_vld_q    <= 1'b0;
      byte_q        <= '0;
      key_down_q    <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      press_count_q <= '0;
      push_q        <= 1'b0;
      word_q        <= '0;
      frame_err_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dat_sync_q    <= dat_sync_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      to_cnt_q      <= to_cnt_d;
      byte_vld_q    <= byte_vld_d;
      byte_q        <= byte_d;
      key_down_q    <= key_down_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      press_count_q <= press_count_d;
      push_q        <= push_d;
      word_q        <= word_d;
      frame_err_q   <= frame_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign ev.ev_valid = (count_q != '0);
  assign ev.ev_data  = ev.ev_valid ? mem_q[rd_ptr_q] : 11'd0;
  assign key_down    = key_down_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign press_count = press_count_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
endmodule
